// File: rtl/layer_seq_pkg.sv
// Shared types and constants for the CNN layer sequencer.
package layer_seq_pkg;

  localparam int unsigned LAYER_IDX_W    = 3;
  localparam int unsigned LOAD_WORDS_DEF = 6144;

  // Load counter width for a given load size (at least 1 bit).
  function automatic int unsigned load_cnt_w(input int unsigned words);
    return (words > 1) ? $clog2(words) : 1;
  endfunction

  localparam int unsigned LOAD_CNT_W = load_cnt_w(LOAD_WORDS_DEF);

  localparam logic [2:0] ST_IDLE_ENC  = 3'd0;
  localparam logic [2:0] ST_LOAD_ENC  = 3'd1;
  localparam logic [2:0] ST_FLUSH_ENC = 3'd2;
  localparam logic [2:0] ST_RUN_ENC   = 3'd3;
  localparam logic [2:0] ST_SWAP_ENC  = 3'd4;
  localparam logic [2:0] ST_DONE_ENC  = 3'd5;
  localparam logic [2:0] ST_ERR_ENC   = 3'd6;

  typedef enum logic [2:0] {
    ST_IDLE  = ST_IDLE_ENC,
    ST_LOAD  = ST_LOAD_ENC,
    ST_FLUSH = ST_FLUSH_ENC,
    ST_RUN   = ST_RUN_ENC,
    ST_SWAP  = ST_SWAP_ENC,
    ST_DONE  = ST_DONE_ENC,
    ST_ERR   = ST_ERR_ENC
  } state_e;

endpackage

// File: rtl/layer_seq_ctrl_watchdog.sv
// Per-layer RUN timeout counter; only present when LAYER_SEQ_WDOG_EN is defined.
`ifdef LAYER_SEQ_WDOG_EN
module seq_watchdog #(
  parameter int unsigned WDOG_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic run_i,
  output logic timeout_c_o
);

  localparam int unsigned CNT_W = $clog2(WDOG_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WDOG_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Count RUN cycles; restart from zero on every RUN entry.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (run_i) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign timeout_c_o = run_i && (cnt_q == CNT_LAST);

endmodule
`endif

// File: rtl/layer_seq_ctrl.sv
// CNN inference sequencer: host feature-map load, then each layer engine in
// turn with a ping-pong bank swap between layers. Define LAYER_SEQ_WDOG_EN
// to add a per-layer RUN timeout that forces the ERR state.
module layer_seq_ctrl
  import layer_seq_pkg::*;
#(
  parameter int unsigned NUM_LAYERS  = 3,
  parameter int unsigned LOAD_WORDS  = 6144,
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned WDOG_CYCLES = 1000000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   host_we,
  input  logic [ADDR_W-1:0]      host_addr,
  input  logic [DATA_W-1:0]      host_din,
  output logic                   buf_we,
  output logic [ADDR_W-1:0]      buf_addr,
  output logic [DATA_W-1:0]      buf_din,
  output logic [NUM_LAYERS-1:0]  layer_en,
  input  logic [NUM_LAYERS-1:0]  layer_fin,
  output logic                   bank_sel,
  output logic [LAYER_IDX_W-1:0] cur_layer,
  output logic                   busy,
  output logic                   done,
  output logic                   err
);

  localparam int unsigned LCNT_W = load_cnt_w(LOAD_WORDS);
  localparam logic [LCNT_W-1:0] LOAD_LAST = LCNT_W'(LOAD_WORDS - 1);
  localparam logic [LAYER_IDX_W-1:0] LAST_LAYER = LAYER_IDX_W'(NUM_LAYERS - 1);

  state_e                 state_q, state_d;
  logic [LCNT_W-1:0]      load_cnt_q, load_cnt_d;
  logic                   bank_sel_q, bank_sel_d;
  logic [LAYER_IDX_W-1:0] cur_layer_q, cur_layer_d;
  logic [NUM_LAYERS-1:0]  layer_en_q, layer_en_d;
  logic                   buf_we_q, buf_we_d;
  logic [ADDR_W-1:0]      buf_addr_q, buf_addr_d;
  logic [DATA_W-1:0]      buf_din_q, buf_din_d;
  logic                   done_q, done_d;
  logic                   err_q, err_d;
  logic                   busy_q, busy_d;

  logic [NUM_LAYERS-1:0]  cur_mask_c;
  logic [NUM_LAYERS-1:0]  next_mask_c;
  logic [NUM_LAYERS-1:0]  exp_fin_c;
  logic                   fin_hit_c;
  logic                   fin_bad_c;
  logic                   wdog_timeout_c;

  // Which fin bit is legitimate this cycle; anything else is an error.
  always_comb begin
    cur_mask_c  = NUM_LAYERS'(1) << cur_layer_q;
    next_mask_c = NUM_LAYERS'(1) << (cur_layer_q + LAYER_IDX_W'(1));
    exp_fin_c   = (state_q == ST_RUN) ? cur_mask_c : '0;
    fin_hit_c   = |(layer_fin & exp_fin_c);
    fin_bad_c   = |(layer_fin & ~exp_fin_c);
  end

`ifdef LAYER_SEQ_WDOG_EN
  logic enter_run_c;
  assign enter_run_c = (state_d == ST_RUN) && (state_q != ST_RUN);

  seq_watchdog #(
    .WDOG_CYCLES (WDOG_CYCLES)
  ) u_wdog (
    .clk         (clk),
    .rst         (rst),
    .clr_i       (enter_run_c),
    .run_i       (state_q == ST_RUN),
    .timeout_c_o (wdog_timeout_c)
  );
`else
  logic unused_wdog;
  assign unused_wdog    = (WDOG_CYCLES == 0);
  assign wdog_timeout_c = 1'b0;
`endif

  // Next state and next registered outputs.
  always_comb begin
    state_d     = state_q;
    load_cnt_d  = load_cnt_q;
    bank_sel_d  = bank_sel_q;
    cur_layer_d = cur_layer_q;
    layer_en_d  = '0;
    buf_we_d    = 1'b0;
    buf_addr_d  = buf_addr_q;
    buf_din_d   = buf_din_q;
    done_d      = 1'b0;
    err_d       = err_q | fin_bad_c;
    busy_d      = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d     = ST_LOAD;
          bank_sel_d  = 1'b0;
          cur_layer_d = '0;
          load_cnt_d  = '0;
        end
      end
      ST_LOAD: begin
        if (host_we) begin
          buf_we_d   = 1'b1;
          buf_addr_d = host_addr;
          buf_din_d  = host_din;
          load_cnt_d = load_cnt_q + LCNT_W'(1);
          if (load_cnt_q == LOAD_LAST) begin
            state_d = ST_FLUSH;
          end
        end
      end
      ST_FLUSH: begin
        state_d    = ST_RUN;
        layer_en_d = cur_mask_c;
      end
      ST_RUN: begin
        if (fin_hit_c) begin
          state_d    = ST_SWAP;
          bank_sel_d = ~bank_sel_q;
        end else if (wdog_timeout_c) begin
          state_d = ST_ERR;
          err_d   = 1'b1;
        end else begin
          layer_en_d = cur_mask_c;
        end
      end
      ST_SWAP: begin
        if (cur_layer_q == LAST_LAYER) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end else begin
          state_d     = ST_RUN;
          cur_layer_d = cur_layer_q + LAYER_IDX_W'(1);
          layer_en_d  = next_mask_c;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      ST_ERR: begin
        if (start) begin
          state_d     = ST_LOAD;
          err_d       = fin_bad_c;
          bank_sel_d  = 1'b0;
          cur_layer_d = '0;
          load_cnt_d  = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE) && (state_d != ST_ERR);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      load_cnt_q  <= '0;
      bank_sel_q  <= 1'b0;
      cur_layer_q <= '0;
      layer_en_q  <= '0;
      buf_we_q    <= 1'b0;
      buf_addr_q  <= '0;
      buf_din_q   <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      load_cnt_q  <= load_cnt_d;
      bank_sel_q  <= bank_sel_d;
      cur_layer_q <= cur_layer_d;
      layer_en_q  <= layer_en_d;
      buf_we_q    <= buf_we_d;
      buf_addr_q  <= buf_addr_d;
      buf_din_q   <= buf_din_d;
      done_q      <= done_d;
      err_q       <= err_d;
      busy_q      <= busy_d;
    end
  end

  assign buf_we    = buf_we_q;
  assign buf_addr  = buf_addr_q;
  assign buf_din   = buf_din_q;
  assign layer_en  = layer_en_q;
  assign bank_sel  = bank_sel_q;
  assign cur_layer = cur_layer_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_layer_seq_ctrl.sv
// Scoreboard bench for layer_seq_ctrl (2 layers, 8-word load).
module tb_layer_seq_ctrl;
  import layer_seq_pkg::*;

  localparam int unsigned NL = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          host_we = 1'b0;
  logic [31:0]   host_addr = '0;
  logic [15:0]   host_din = '0;
  logic          buf_we;
  logic [31:0]   buf_addr;
  logic [15:0]   buf_din;
  logic [NL-1:0] layer_en;
  logic [NL-1:0] layer_fin = '0;
  logic          bank_sel;
  logic [2:0]    cur_layer;
  logic          busy;
  logic          done;
  logic          err;

  layer_seq_ctrl #(
    .NUM_LAYERS  (NL),
    .LOAD_WORDS  (8),
    .ADDR_W      (32),
    .DATA_W      (16),
    .WDOG_CYCLES (50)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .host_we   (host_we),
    .host_addr (host_addr),
    .host_din  (host_din),
    .buf_we    (buf_we),
    .buf_addr  (buf_addr),
    .buf_din   (buf_din),
    .layer_en  (layer_en),
    .layer_fin (layer_fin),
    .bank_sel  (bank_sel),
    .cur_layer (cur_layer),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [31:0] addr; logic [15:0] data; int at; } wr_t;
  typedef struct { logic [NL-1:0] en; logic bank; int at; } en_t;

  wr_t wr_q[$];
  en_t en_q[$];
  int  done_q[$];

  int n_chk  = 0;
  int n_pass = 0;
  bit mon_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: pop expectations whenever the DUT presents a write, an enable/bank change or done.
  logic [NL:0] prev_en = '0;
  wr_t         we_e;
  en_t         ee_e;
  int          de_e;
  always @(negedge clk) begin
    if (mon_en) begin
      if (buf_we) begin
        if (wr_q.size() == 0) chk("wr_unexpected", 64'(buf_we), 64'(0));
        else begin
          we_e = wr_q.pop_front();
          chk("wr_addr", 64'(buf_addr), 64'(we_e.addr));
          chk("wr_data", 64'(buf_din), 64'(we_e.data));
          chk("wr_cycle", 64'(cyc), 64'(we_e.at));
        end
      end
      if ({layer_en, bank_sel} !== prev_en) begin
        if (en_q.size() == 0) chk("en_unexpected", 64'({layer_en, bank_sel}), 64'(prev_en));
        else begin
          ee_e = en_q.pop_front();
          chk("layer_en", 64'(layer_en), 64'(ee_e.en));
          chk("bank_sel", 64'(bank_sel), 64'(ee_e.bank));
          chk("en_cycle", 64'(cyc), 64'(ee_e.at));
        end
      end
      if (done) begin
        if (done_q.size() == 0) chk("done_unexpected", 64'(done), 64'(0));
        else begin
          de_e = done_q.pop_front();
          chk("done_cycle", 64'(cyc), 64'(de_e));
          chk("done_bank", 64'(bank_sel), 64'(0));
        end
      end
    end
    prev_en <= {layer_en, bank_sel};
  end

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Host writes addr/data base+i; the final word of a full load also schedules layer 0 enable.
  task automatic load_words(input int abase, input int dbase, input int n, input bit last);
    for (int i = 0; i < n; i++) begin
      host_we   = 1'b1;
      host_addr = 32'(abase + i);
      host_din  = 16'(dbase + i);
      wr_q.push_back('{32'(abase + i), 16'(dbase + i), cyc + 1});
      if (last && i == n - 1) en_q.push_back('{2'b01, 1'b0, cyc + 2});
      tick();
    end
    host_we = 1'b0;
  endtask

  int r;

  initial begin
    // Reset state
    tick(); tick();
    chk("rst_buf_we", 64'(buf_we), 0);
    chk("rst_layer_en", 64'(layer_en), 0);
    chk("rst_bank", 64'(bank_sel), 0);
    chk("rst_busy", 64'(busy), 0);
    chk("rst_done", 64'(done), 0);
    chk("rst_err", 64'(err), 0);
    chk("rst_state", 64'(dut.state_q), 64'(ST_IDLE));
    rst = 1'b0;
    mon_en = 1'b1;
    tick();

    // Write in IDLE is dropped
    host_we = 1'b1; host_addr = 32'd99; host_din = 16'd1;
    tick();
    host_we = 1'b0;
    tick();

    // Run A: full sequence with ignored write/start in RUN
    do_start();
    chk("a_busy_load", 64'(busy), 1);
    chk("a_state_load", 64'(dut.state_q), 64'(ST_LOAD));
    load_words(0, 10000, 8, 1'b1);
    chk("a_state_flush", 64'(dut.state_q), 64'(ST_FLUSH));
    tick();
    chk("a_state_run", 64'(dut.state_q), 64'(ST_RUN));
    host_we = 1'b1; host_addr = 32'd55; host_din = 16'd1; start = 1'b1;
    tick();
    host_we = 1'b0; start = 1'b0;
    repeat (19) tick();
    layer_fin = 2'b01;
    en_q.push_back('{2'b00, 1'b1, cyc + 1});
    en_q.push_back('{2'b10, 1'b1, cyc + 2});
    tick();
    layer_fin = '0;
    chk("a_state_swap", 64'(dut.state_q), 64'(ST_SWAP));
    tick();
    chk("a_cur_layer", 64'(cur_layer), 1);
    repeat (5) tick();
    layer_fin = 2'b10;
    en_q.push_back('{2'b00, 1'b0, cyc + 1});
    done_q.push_back(cyc + 2);
    tick();
    layer_fin = '0;
    tick();
    chk("a_done_busy", 64'(busy), 1);
    tick();
    chk("a_idle", 64'(dut.state_q), 64'(ST_IDLE));
    chk("a_done_low", 64'(done), 0);
    chk("a_busy_low", 64'(busy), 0);
    chk("a_err_clean", 64'(err), 0);

    // Run B: spurious fin, then reset during layer 1
    do_start();
    load_words(100, 20000, 8, 1'b1);
    tick();
    layer_fin = 2'b10;
    tick();
    layer_fin = '0;
    chk("b_err_set", 64'(err), 1);
    chk("b_state_run", 64'(dut.state_q), 64'(ST_RUN));
    chk("b_en_held", 64'(layer_en), 64'(2'b01));
    tick(); tick();
    layer_fin = 2'b01;
    en_q.push_back('{2'b00, 1'b1, cyc + 1});
    en_q.push_back('{2'b10, 1'b1, cyc + 2});
    tick();
    layer_fin = '0;
    repeat (4) tick();
    rst = 1'b1;
    en_q.push_back('{2'b00, 1'b0, cyc + 1});
    tick();
    rst = 1'b0;
    chk("b_rst_state", 64'(dut.state_q), 64'(ST_IDLE));
    chk("b_rst_err", 64'(err), 0);
    chk("b_rst_busy", 64'(busy), 0);
    chk("b_rst_cur", 64'(cur_layer), 0);
    chk("b_rst_outs", 64'({buf_we, layer_en, bank_sel, done}), 0);

    // Run C: partial load, reset, full reload; fins in first RUN cycles
    do_start();
    load_words(0, 30000, 3, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    do_start();
    load_words(0, 40000, 7, 1'b0);
    chk("c_still_load", 64'(dut.state_q), 64'(ST_LOAD));
    load_words(7, 40007, 1, 1'b1);
    chk("c_flush", 64'(dut.state_q), 64'(ST_FLUSH));
    tick();
    r = cyc;
    layer_fin = 2'b01;
    en_q.push_back('{2'b00, 1'b1, r + 1});
    en_q.push_back('{2'b10, 1'b1, r + 2});
    tick();
    layer_fin = '0;
    tick();
    layer_fin = 2'b10;
    en_q.push_back('{2'b00, 1'b0, r + 3});
    done_q.push_back(r + 4);
    tick();
    layer_fin = '0;
    tick();
    chk("c_done_high", 64'(done), 1);
    chk("c_min_cycles", 64'(cyc - r + 1), 5);
    tick();
    chk("c_done_low", 64'(done), 0);

`ifdef LAYER_SEQ_WDOG_EN
    // Run D: no fin, watchdog forces ERR
    do_start();
    load_words(0, 50000, 8, 1'b1);
    tick();
    en_q.push_back('{2'b00, 1'b0, cyc + 50});
    repeat (49) tick();
    chk("d_run_49", 64'(dut.state_q), 64'(ST_RUN));
    tick();
    chk("d_err_state", 64'(dut.state_q), 64'(ST_ERR));
    chk("d_err_flag", 64'(err), 1);
    chk("d_err_busy", 64'(busy), 0);
    do_start();
    chk("d_restart", 64'(dut.state_q), 64'(ST_LOAD));
    chk("d_err_clr", 64'(err), 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
`endif

    repeat (3) tick();
    chk("wr_q_empty", 64'(wr_q.size()), 0);
    chk("en_q_empty", 64'(en_q.size()), 0);
    chk("done_q_empty", 64'(done_q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/layer_seq_ctrl.md
# layer_seq_ctrl

Top-level sequencer for the CNN inference pipeline. It accepts the host's input-feature-map load stream into the data buffer, then runs each layer engine (C1S2, C3S4, …) in turn. Each engine is enabled and held until its `work_finished` pulse arrives. Between layers the controller toggles the ping-pong buffer bank, so each layer reads the previous layer's output. It sits between the host load port and the layer engines, owning the buffer write port during load and the buffer bank select throughout.

## Interface
Parameters:
- NUM_LAYERS, 3, number of sequenced layer engines (1..8)
- LOAD_WORDS, 6144, 16-bit words per input load (6*1024)
- ADDR_W, 32, buffer address width
- DATA_W, 16, buffer data width
- WDOG_CYCLES, 1000000, per-layer timeout (used only with watchdog compiled in)

Ports:
- Clock and reset: one clock; reset is synchronous and active-high. The ports are named `clk` and `rst` (the codebase names its clock and reset ports this way).
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  begin inference; sampled in IDLE and ERR only
- host_we  in  1  host write strobe
- host_addr  in  ADDR_W  host write address
- host_din  in  DATA_W  host write data
- buf_we  out  1  write enable to bank-0 data buffer port B
- buf_addr  out  ADDR_W  registered host_addr
- buf_din  out  DATA_W  registered host_din
- layer_en  out  NUM_LAYERS  one-hot level enable to layer engines
- layer_fin  in  NUM_LAYERS  work_finished pulses from engines
- bank_sel  out  1  bank read by the active layer; its output goes to the other bank
- cur_layer  out  3  index of the active or next layer
- busy  out  1  high in every state except IDLE and ERR
- done  out  1  one-cycle pulse at end of the final layer
- err  out  1  sticky error flag

## Operation
- States: IDLE, LOAD, FLUSH, RUN, SWAP, DONE, ERR. All outputs are registered and update together with the state.
- Reset, from any state and mid-operation: go to IDLE; every output 0; load_cnt=0; watchdog cleared.
- IDLE: on start, go to LOAD with bank_sel=0, cur_layer=0, load_cnt=0.
- LOAD:
  - Each host_we is forwarded to buf_we/buf_addr/buf_din one cycle later, and load_cnt is incremented.
  - A host_we with load_cnt==LOAD_WORDS-1 moves to FLUSH.
  - host_we in any other state is dropped: buf_we stays 0 and nothing is counted.
- FLUSH: one cycle, so the last buffer write commits. Then go to RUN.
- RUN:
  - layer_en[cur_layer]=1; all other layer_en bits are 0.
  - layer_fin[cur_layer]=1 goes to SWAP, and layer_en drops in the same cycle SWAP is entered.
  - Any other layer_fin bit, in any state, sets err but causes no transition.
- SWAP: one cycle with layer_en all 0; bank_sel toggles.
  - If cur_layer==NUM_LAYERS-1, go to DONE.
  - Otherwise cur_layer increments and the next state is RUN.
- DONE: done=1 for one cycle, then IDLE. bank_sel retains the bank holding the final result.
- ERR: layer_en=0, err=1, busy=0. start clears err and enters LOAD as from IDLE.
- start while busy is ignored.
- A layer_fin arriving in the first RUN cycle is accepted.

## Timing
- start at edge k gives LOAD in cycle k+1.
- host write latency is 1 cycle (buf_* registered).
- The last load write at edge m gives FLUSH at m+1 and RUN at m+2, with layer_en rising at m+2.
- The fin pulse at edge r gives SWAP at r+1 and the next RUN at r+2, so layer_en is low for exactly 1 cycle between layers.
- The final fin at edge r gives done high in cycle r+2.
- Minimum total for N layers, counted from the first RUN cycle: N*(t_layer+1)+1 cycles.

## Configuration
- LAYER_SEQ_WDOG_EN defined:
  - A counter clears on entering RUN and increments every RUN cycle.
  - If it reaches WDOG_CYCLES-1 without the active fin, the next state is ERR.
- LAYER_SEQ_WDOG_EN undefined: RUN waits indefinitely and err is set only by an unexpected layer_fin.

## Structure
- Package layer_seq_pkg contains:
  - the state enum (3 bits)
  - localparams for state encodings, LOAD_CNT_W=$clog2(LOAD_WORDS) and LAYER_IDX_W=3
- Sub-module seq_watchdog (counter plus timeout flag) is instantiated only under LAYER_SEQ_WDOG_EN.

## Test plan
- Load: NUM_LAYERS=2, LOAD_WORDS=8. Pulse start, then write 8 words with addr 0..7 and data 10000..10007.
  - buf_we is high for 8 cycles, each one cycle behind its host write.
  - FLUSH follows, then layer_en=2'b01.
- Sequence: fin[0] 20 cycles after RUN.
  - layer_en goes 01→00 for 1 cycle, then 10; bank_sel goes 0→1.
  - fin[1] then gives bank_sel=0 and done high for exactly 1 cycle, 2 cycles after fin[1].
- Spurious fin: during RUN of layer 0, pulse fin[1].
  - err=1; state stays RUN; layer_en remains 01.
- Ignored writes/starts: host_we pulses in IDLE and RUN, and start pulsed in RUN.
  - buf_we stays 0 outside LOAD; load_cnt and the sequence are unaffected.
- Reset mid-RUN: assert rst for 1 cycle during layer 1.
  - The next cycle has every output 0 and state IDLE.
  - A new start reloads from load_cnt=0.
- Watchdog (macro defined, WDOG_CYCLES=50): no fin.
  - The state is ERR 50 cycles after entering RUN, with layer_en=0 and err=1.
  - start then clears err and enters LOAD.
